// File: rtl/collision_scanner.sv
// Per-frame frog/car collision scanner: snapshots all sprites on frame_tick, tests one
// car per clock with a bounding-box overlap, then reports death/win pulses with a frame grace window.
module collision_scanner #(
  parameter int NUM_CARS     = 11,
  parameter int COORD_W      = 10,
  parameter int FROG_W       = 32,
  parameter int CAR_W        = 32,
  parameter int CAR_H        = 32,
  parameter int WIN_Y        = 0,
  parameter int GRACE_FRAMES = 30,
  localparam int IDX_W       = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_tick,
  input  logic [COORD_W-1:0]           frog_x,
  input  logic [COORD_W-1:0]           frog_y,
  input  logic [NUM_CARS*COORD_W-1:0]  car_x_bus,
  input  logic [NUM_CARS*COORD_W-1:0]  car_y_bus,
  input  logic [NUM_CARS-1:0]          car_en,
  output logic                         death_collision,
  output logic                         win_collision,
  output logic [IDX_W-1:0]             hit_index,
  output logic                         scan_busy,
  output logic                         grace_active,
  output logic                         tick_overrun
);

  localparam int SUM_W   = COORD_W + 1;
  localparam int GRACE_W = $clog2(GRACE_FRAMES + 2);
  // The accept edge of the very next scan already consumes one count, so one extra
  // count is loaded to keep GRACE_FRAMES whole frames suppressed.
  localparam logic [GRACE_W-1:0] GRACE_LOAD =
    GRACE_W'((GRACE_FRAMES == 0) ? 0 : GRACE_FRAMES + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_CARS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  function automatic logic overlap(input logic en,
                                   input logic [COORD_W-1:0] fx, input logic [COORD_W-1:0] fy,
                                   input logic [COORD_W-1:0] cx, input logic [COORD_W-1:0] cy);
    logic [SUM_W-1:0] fx_e, fy_e, cx_e, cy_e;
    fx_e = {1'b0, fx};
    fy_e = {1'b0, fy};
    cx_e = {1'b0, cx};
    cy_e = {1'b0, cy};
    return en &&
           (fx_e < cx_e + SUM_W'(CAR_W)) && (cx_e < fx_e + SUM_W'(FROG_W)) &&
           (fy_e < cy_e + SUM_W'(CAR_H)) && (cy_e < fy_e + SUM_W'(FROG_W));
  endfunction

  function automatic logic [GRACE_W-1:0] grace_dec(input logic [GRACE_W-1:0] g);
    return (g == '0) ? '0 : g - 1'b1;
  endfunction

  state_t               state_q;
  logic [COORD_W-1:0]   frog_x_q, frog_y_q;
  logic [COORD_W-1:0]   car_x_q [NUM_CARS];
  logic [COORD_W-1:0]   car_y_q [NUM_CARS];
  logic [NUM_CARS-1:0]  car_en_q;
  logic [IDX_W-1:0]     idx_q, pend_idx_q, hit_index_q;
  logic                 hit_q;
  logic [GRACE_W-1:0]   grace_q;
  logic                 death_q, win_q, overrun_q;

  logic                 overlap_d, death_d, win_d;

  always_comb begin
    overlap_d = overlap(car_en_q[idx_q], frog_x_q, frog_y_q, car_x_q[idx_q], car_y_q[idx_q]);
    death_d   = hit_q && (grace_q == '0);
    win_d     = (frog_y_q == COORD_W'(WIN_Y)) && !death_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      frog_x_q    <= '0;
      frog_y_q    <= '0;
      for (int i = 0; i < NUM_CARS; i++) begin
        car_x_q[i] <= '0;
        car_y_q[i] <= '0;
      end
      car_en_q    <= '0;
      idx_q       <= '0;
      pend_idx_q  <= '0;
      hit_index_q <= '0;
      hit_q       <= 1'b0;
      grace_q     <= '0;
      death_q     <= 1'b0;
      win_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      death_q   <= 1'b0;
      win_q     <= 1'b0;
      overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_tick) begin
            frog_x_q <= frog_x;
            frog_y_q <= frog_y;
            for (int i = 0; i < NUM_CARS; i++) begin
              car_x_q[i] <= car_x_bus[i*COORD_W +: COORD_W];
              car_y_q[i] <= car_y_bus[i*COORD_W +: COORD_W];
            end
            car_en_q <= car_en;
            hit_q    <= 1'b0;
            idx_q    <= '0;
            grace_q  <= grace_dec(grace_q);
            state_q  <= SCAN;
          end
        end
        SCAN: begin
          overrun_q <= frame_tick;
          // First overlap wins: later hits never displace the lowest index.
          if (overlap_d && !hit_q) begin
            hit_q      <= 1'b1;
            pend_idx_q <= idx_q;
          end
          if (idx_q == LAST_IDX) begin
            state_q <= REPORT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        REPORT: begin
          overrun_q <= frame_tick;
          if (death_d) begin
            death_q     <= 1'b1;
            hit_index_q <= pend_idx_q;
            grace_q     <= GRACE_LOAD;
          end
          win_q   <= win_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign death_collision = death_q;
  assign win_collision   = win_q;
  assign hit_index       = hit_index_q;
  assign scan_busy       = (state_q != IDLE);
  assign grace_active    = (grace_q != '0);
  assign tick_overrun    = overrun_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Scoreboard bench for collision_scanner: expected scan results are queued at each tick
// and compared when the scan completes (scan_busy falls).
module tb_collision_scanner;
  localparam int N     = 11;
  localparam int CW    = 10;
  localparam int GRACE = 30;

  logic               clk = 1'b0;
  logic               reset, frame_tick;
  logic [CW-1:0]      frog_x, frog_y;
  logic [N*CW-1:0]    car_x_bus, car_y_bus;
  logic [N-1:0]       car_en;
  logic               death_collision, win_collision, scan_busy, grace_active, tick_overrun;
  logic [3:0]         hit_index;

  always #5 clk = ~clk;

  collision_scanner #(
    .NUM_CARS(N), .COORD_W(CW), .FROG_W(32), .CAR_W(32), .CAR_H(32),
    .WIN_Y(0), .GRACE_FRAMES(GRACE)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .frog_x(frog_x), .frog_y(frog_y),
    .car_x_bus(car_x_bus), .car_y_bus(car_y_bus), .car_en(car_en),
    .death_collision(death_collision), .win_collision(win_collision),
    .hit_index(hit_index), .scan_busy(scan_busy),
    .grace_active(grace_active), .tick_overrun(tick_overrun)
  );

  typedef struct {
    logic       death;
    logic       win;
    logic [3:0] idx;
    logic       grace;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  int     errors = 0, checks = 0, reports = 0, deaths = 0;
  logic   prev_busy = 1'b0;

  // Stimulus/model state
  int     fx, fy;
  int     cx[N], cy[N];
  logic [N-1:0] en;
  int     scan_no, last_death, exp_idx;
  bit     has_death;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit ovl(input int f_x, input int f_y, input int c_x, input int c_y, input bit e);
    return e && (f_x < c_x + 32) && (c_x < f_x + 32) && (f_y < c_y + 32) && (c_y < f_y + 32);
  endfunction

  task automatic set_far();
    for (int i = 0; i < N; i++) begin
      cx[i] = 600;
      cy[i] = 600;
    end
    en = '1;
  endtask

  task automatic model_clear();
    has_death = 0;
    exp_idx   = 0;
    scan_no   = 0;
    last_death = 0;
  endtask

  task automatic tick(input bit push);
    exp_t e;
    bit   hit;
    int   hi;
    hit = 0;
    hi  = 0;
    for (int i = 0; i < N; i++)
      if (!hit && ovl(fx, fy, cx[i], cy[i], en[i])) begin
        hit = 1;
        hi  = i;
      end
    scan_no++;
    e.death = hit && (!has_death || (scan_no - last_death) > GRACE);
    if (e.death) begin
      has_death  = 1;
      last_death = scan_no;
      exp_idx    = hi;
    end
    e.win   = (fy == 0) && !e.death;
    e.idx   = 4'(exp_idx);
    e.grace = has_death && ((scan_no - last_death) <= GRACE);
    if (push) sb_q.push_back(e);
    @(posedge clk); #1;
    frog_x = CW'(fx);
    frog_y = CW'(fy);
    for (int i = 0; i < N; i++) begin
      car_x_bus[i*CW +: CW] = CW'(cx[i]);
      car_y_bus[i*CW +: CW] = CW'(cy[i]);
    end
    car_en     = en;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scan_busy && n < 50);
    chk("scan_done", scan_busy, 0);
    @(negedge clk);
  endtask

  task automatic run_scan();
    tick(1);
    wait_idle();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  // Report monitor: a scan ends on the first sample where scan_busy has dropped.
  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !scan_busy) begin
        reports++;
        if (death_collision) deaths++;
        chk("sb_size", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          chk("death", death_collision, mon_e.death);
          chk("win", win_collision, mon_e.win);
          chk("hit_index", hit_index, mon_e.idx);
          chk("grace", grace_active, mon_e.grace);
        end
      end else if (death_collision || win_collision) begin
        chk("spurious_pulse", {death_collision, win_collision}, 0);
      end
      prev_busy = scan_busy;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, pl;
    reset = 1'b1;
    frame_tick = 1'b0;
    frog_x = '0; frog_y = '0;
    car_x_bus = '0; car_y_bus = '0; car_en = '0;
    model_clear();
    set_far();
    fx = 100; fy = 200;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_death", death_collision, 0);
    chk("rst_win", win_collision, 0);
    chk("rst_idx", hit_index, 0);
    chk("rst_busy", scan_busy, 0);
    chk("rst_grace", grace_active, 0);
    chk("rst_overrun", tick_overrun, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Basic hit: lowest index (3) wins over car 7, exact latency of 12 cycles
    cx[3] = 90;  cy[3] = 200;
    cx[7] = 110; cy[7] = 210;
    tick(1);
    repeat (12) @(negedge clk);
    chk("lat_early", death_collision, 0);
    @(negedge clk);
    chk("lat_death", death_collision, 1);
    chk("lat_idx", hit_index, 3);
    chk("lat_grace", grace_active, 1);
    chk("lat_win", win_collision, 0);
    wait_idle();
    do_reset();

    // Touching edge and disabled cars never collide
    set_far();
    fx = 100; fy = 200;
    cx[0] = 132;  cy[0] = 200;
    cx[1] = 1000; cy[1] = 1000; en[1] = 1'b0;
    cx[2] = 100;  cy[2] = 200;  en[2] = 1'b0;
    d0 = deaths;
    repeat (3) run_scan();
    chk("no_death_touch", deaths - d0, 0);

    // Goal row: win alone, then death suppresses win
    set_far();
    fx = 0; fy = 0;
    run_scan();
    cx[0] = 0; cy[0] = 0;
    run_scan();
    do_reset();

    // Continuous hit: deaths on scans 1 and 32, grace falls at the tick of scan 32
    set_far();
    fx = 100; fy = 200;
    cx[3] = 90; cy[3] = 200;
    d0 = deaths;
    for (int s = 1; s <= 33; s++) begin
      pl = last_death;
      tick(1);
      if (s > 1) chk("grace_at_tick", grace_active, ((s - pl) <= GRACE) ? 1 : 0);
      wait_idle();
    end
    chk("grace_deaths", deaths - d0, 2);
    do_reset();

    // Right screen edge: sums past 1023 must not wrap
    set_far();
    fx = 1000; fy = 200;
    cx[0] = 1020; cy[0] = 200;
    run_scan();
    do_reset();
    cx[0] = 5;
    d0 = deaths;
    run_scan();
    chk("edge_no_hit", deaths - d0, 0);
    do_reset();

    // Overrun: second tick while busy is dropped
    set_far();
    fx = 100; fy = 200;
    cx[3] = 90; cy[3] = 200;
    r0 = reports;
    tick(1);
    repeat (3) @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(negedge clk);
    chk("overrun", tick_overrun, 1);
    @(negedge clk);
    chk("overrun_clr", tick_overrun, 0);
    wait_idle();
    repeat (20) @(negedge clk);
    chk("one_report", reports - r0, 1);
    chk("grace_before_abort", grace_active, 1);

    // Reset mid-scan aborts without any pulse and clears grace
    tick(0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_death", death_collision, 0);
    chk("abort_win", win_collision, 0);
    chk("abort_busy", scan_busy, 0);
    chk("abort_grace", grace_active, 0);
    chk("abort_idx", hit_index, 0);
    chk("abort_overrun", tick_overrun, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    r0 = reports;
    repeat (20) @(negedge clk);
    chk("abort_no_report", reports - r0, 0);
    run_scan();

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
